gray_counter: RTL and testbench

GRAY_COUNTER -- requirements
Module: gray_counter

---
 rtl/gray_counter.sv | 68 ++++++
 tb/tb_gray_counter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/gray_counter.sv
// Up/down counter with a binary count register and a Gray-coded shadow register.
// Supports a synchronous Gray-code load and either wrap-around or saturation at the terminal count.
module gray_counter #(
  parameter int WIDTH = 3,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] o,
  output logic             tc
);

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_tc;

  logic [WIDTH-1:0] w_load_bin;
  logic [WIDTH-1:0] w_step_bin;
  logic [WIDTH-1:0] w_next_bin;
  logic             w_at_term;
  logic             w_next_tc;

  // Gray-to-binary: bit k is the XOR of all Gray bits at and above k.
  always_comb begin
    w_load_bin = '0;
    for (int k = 0; k < WIDTH; k++) begin
      w_load_bin[k] = ^(i >> k);
    end
  end

  always_comb begin
    w_at_term  = up ? (r_bin == {WIDTH{1'b1}}) : (r_bin == {WIDTH{1'b0}});
    w_step_bin = up ? (r_bin + 1'b1) : (r_bin - 1'b1);
    w_next_bin = r_bin;
    w_next_tc  = 1'b0;
    if (load) begin
      w_next_bin = w_load_bin;
    end else if (en) begin
      w_next_tc = w_at_term;
      if (!(w_at_term && (WRAP == 1'b0))) begin
        w_next_bin = w_step_bin;
      end
    end
  end

  // Gray register is derived from the next binary value so both update on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin  <= '0;
      r_gray <= '0;
      r_tc   <= 1'b0;
    end else begin
      r_bin  <= w_next_bin;
      r_gray <= w_next_bin ^ (w_next_bin >> 1);
      r_tc   <= w_next_tc;
    end
  end

  assign bin = r_bin;
  assign o   = r_gray;
  assign tc  = r_tc;

endmodule

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter: 3-bit wrap and saturate instances share one stimulus table,
// an 8-bit wrap instance is swept through full up and down cycles.
module tb_gray_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, up, load;
  logic [2:0] i;
  logic [2:0] bin_w, o_w, bin_s, o_s;
  logic       tc_w, tc_s;

  logic       en8, up8, load8;
  logic [7:0] i8, bin8, o8;
  logic       tc8;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  gray_counter #(.WIDTH(3), .WRAP(1'b1)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .i(i),
    .bin(bin_w), .o(o_w), .tc(tc_w)
  );

  gray_counter #(.WIDTH(3), .WRAP(1'b0)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .i(i),
    .bin(bin_s), .o(o_s), .tc(tc_s)
  );

  gray_counter #(.WIDTH(8), .WRAP(1'b1)) u_wide (
    .clk(clk), .rst(rst), .en(en8), .up(up8), .load(load8), .i(i8),
    .bin(bin8), .o(o8), .tc(tc8)
  );

  typedef struct {
    logic       load;
    logic       en;
    logic       up;
    logic [2:0] i;
    logic [2:0] bw;
    logic       tw;
    logic [2:0] bs;
    logic       ts;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input logic l, input logic e, input logic u, input logic [2:0] gi,
                              input logic [2:0] bw, input logic tw, input logic [2:0] bs, input logic ts);
    vec_t v;
    v.load = l; v.en = e; v.up = u; v.i = gi;
    v.bw = bw; v.tw = tw; v.bs = bs; v.ts = ts;
    return v;
  endfunction

  function automatic logic [7:0] gray_of(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check3(input string tag, input logic [2:0] bw, input logic tw,
                        input logic [2:0] bs, input logic ts);
    check({tag, " bin_w"}, 32'(bin_w), 32'(bw));
    check({tag, " o_w"},   32'(o_w),   32'(gray_of(8'(bw))));
    check({tag, " tc_w"},  32'(tc_w),  32'(tw));
    check({tag, " bin_s"}, 32'(bin_s), 32'(bs));
    check({tag, " o_s"},   32'(o_s),   32'(gray_of(8'(bs))));
    check({tag, " tc_s"},  32'(tc_s),  32'(ts));
  endtask

  task automatic drive3(input logic l, input logic e, input logic u, input logic [2:0] gi);
    load = l; en = e; up = u; i = gi;
  endtask

  // Drives at a falling edge, lets one rising edge act, samples at the next falling edge.
  task automatic step3(input logic l, input logic e, input logic u, input logic [2:0] gi);
    drive3(l, e, u, gi);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] exp_b, prev_o;
    int         tc_pulses;

    for (int k = 0; k < 7; k++) vecs[k] = mk(0, 1, 1, 3'b000, 3'(k + 1), 0, 3'(k + 1), 0);
    vecs[7]  = mk(0, 1, 1, 3'b000, 3'd0, 1, 3'd7, 1);
    vecs[8]  = mk(0, 1, 1, 3'b000, 3'd1, 0, 3'd7, 1);
    vecs[9]  = mk(0, 1, 1, 3'b000, 3'd2, 0, 3'd7, 1);
    vecs[10] = mk(0, 1, 0, 3'b000, 3'd1, 0, 3'd6, 0);
    vecs[11] = mk(0, 0, 0, 3'b000, 3'd1, 0, 3'd6, 0);
    vecs[12] = mk(1, 0, 1, 3'b100, 3'd7, 0, 3'd7, 0);
    vecs[13] = mk(1, 1, 1, 3'b110, 3'd4, 0, 3'd4, 0);
    vecs[14] = mk(0, 1, 1, 3'b000, 3'd5, 0, 3'd5, 0);
    vecs[15] = mk(1, 0, 0, 3'b000, 3'd0, 0, 3'd0, 0);
    vecs[16] = mk(0, 1, 0, 3'b000, 3'd7, 1, 3'd0, 1);
    vecs[17] = mk(0, 1, 0, 3'b000, 3'd6, 0, 3'd0, 1);
    vecs[18] = mk(0, 1, 1, 3'b000, 3'd7, 0, 3'd1, 0);
    vecs[19] = mk(0, 0, 1, 3'b000, 3'd7, 0, 3'd1, 0);
    vecs[20] = mk(0, 1, 1, 3'b000, 3'd0, 1, 3'd2, 0);
    vecs[21] = mk(1, 1, 0, 3'b000, 3'd0, 0, 3'd0, 0);

    // Clock/reset
    rst = 1'b1; drive3(0, 0, 0, 3'b000);
    en8 = 1'b0; up8 = 1'b0; load8 = 1'b0; i8 = '0;
    repeat (2) @(negedge clk);
    check3("reset", 3'd0, 0, 3'd0, 0);
    check("reset bin8", 32'(bin8), 32'd0);
    check("reset tc8",  32'(tc8),  32'd0);
    rst = 1'b0;

    for (int v = 0; v < 22; v++) begin
      step3(vecs[v].load, vecs[v].en, vecs[v].up, vecs[v].i);
      check3($sformatf("vec%0d", v), vecs[v].bw, vecs[v].tw, vecs[v].bs, vecs[v].ts);
    end

    // Asynchronous reset between edges at bin=5, en held through reset
    step3(1, 0, 1, 3'b111);
    check3("load5", 3'd5, 0, 3'd5, 0);
    drive3(0, 0, 1, 3'b000);
    @(posedge clk);
    #2;
    rst = 1'b1; en = 1'b1; load = 1'b1; i = 3'b011;
    #1;
    check3("async_rst", 3'd0, 0, 3'd0, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check3($sformatf("in_rst%0d", k), 3'd0, 0, 3'd0, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    step3(0, 1, 1, 3'b000);
    check3("post_rst", 3'd1, 0, 3'd1, 0);

    // tc high at reset assertion must clear without a clock edge
    step3(0, 1, 0, 3'b000);
    check3("dn1", 3'd0, 0, 3'd0, 0);
    step3(0, 1, 0, 3'b000);
    check3("dn2", 3'd7, 1, 3'd0, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check3("async_tc", 3'd0, 0, 3'd0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive3(0, 0, 0, 3'b000);

    // 8-bit full sweep: 256 up-steps then 256 down-steps
    exp_b = 8'd0;
    prev_o = o8;
    for (int dir = 1; dir >= 0; dir--) begin
      tc_pulses = 0;
      up8 = dir[0];
      en8 = 1'b1;
      for (int s = 0; s < 256; s++) begin
        logic       exp_tc;
        logic [7:0] e;
        exp_tc = dir[0] ? (exp_b == 8'hFF) : (exp_b == 8'h00);
        exp_b  = dir[0] ? exp_b + 8'd1 : exp_b - 8'd1;
        exp_q.push_back(exp_b);
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        check($sformatf("w8 d%0d s%0d bin", dir, s), 32'(bin8), 32'(e));
        check($sformatf("w8 d%0d s%0d o", dir, s), 32'(o8), 32'(gray_of(e)));
        check($sformatf("w8 d%0d s%0d onebit", dir, s), 32'($countones(o8 ^ prev_o)), 32'd1);
        check($sformatf("w8 d%0d s%0d tc", dir, s), 32'(tc8), 32'(exp_tc));
        if (tc8 === 1'b1) tc_pulses++;
        prev_o = o8;
      end
      check($sformatf("w8 d%0d tc_pulses", dir), 32'(tc_pulses), 32'd1);
    end
    en8 = 1'b0;
    @(negedge clk);
    check("w8 final bin", 32'(bin8), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
